// File: rtl/fetch_stage_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam int          MAX_OUTST_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_resp_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// SRAM-like instruction bus: address handshake plus in-order data responses.
interface fetch_stage_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head, used for request tags and buffered responses.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] slots [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q, slot_d;
    assign wr_en[gi] = push & ~clr & (wr_q == PW'(gi));
    always_comb begin
      slot_d = slot_q;
      if (wr_en[gi]) slot_d = din;
    end
    always_ff @(posedge clk) slot_q <= slot_d;
    assign slots[gi] = slot_q;
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = slots[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clr && cnt_q == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clr && cnt_q == '0));

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC generation, instruction-bus requests,
// response buffering with discard of squashed fetches, and the decode-side register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MAX_OUTST = MAX_OUTST_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stallF,
  input  logic          stallD,
  input  logic          flushD,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master ibus,
  output logic [31:0]   pcF,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic [31:0]   pc_plus4D,
  output logic          validD
);

  localparam int CW = $clog2(MAX_OUTST+1);

  logic [31:0]   pcf_q, pcf_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   instrd_q, instrd_d, pcd_q, pcd_d, pc_plus4d_q, pc_plus4d_d;
  logic          validd_q, validd_d;

  logic [CW-1:0] tag_cnt, buf_cnt;
  logic          tag_empty, buf_empty;
  logic [31:0]   tag_head;
  fetch_resp_t   buf_head, buf_in;
  logic          redir, hs, data_ok, keep, bypass, buf_push, buf_pop;

  assign ibus.inst_req  = resetn & ~stallF &
                          (({1'b0, tag_cnt} + {1'b0, buf_cnt}) < (CW+1)'(MAX_OUTST));
  assign ibus.inst_addr = pcf_q;

  always_comb begin
    redir    = redirect & ~stallD;
    hs       = ibus.inst_req & ibus.inst_addr_ok;
    data_ok  = ibus.inst_data_ok;
    // A response is kept only if it belongs to the current fetch stream.
    keep     = data_ok & (discard_q == '0) & ~redir;
    bypass   = keep & buf_empty & ~stallD & ~flushD;
    buf_push = keep & ~bypass;
    buf_pop  = ~buf_empty & ~stallD & ~flushD & ~redir;
    buf_in   = '{pc: tag_head, instr: ibus.inst_rdata};
  end

  always_comb begin
    pcf_d       = pcf_q;
    discard_d   = discard_q;
    instrd_d    = instrd_q;
    pcd_d       = pcd_q;
    pc_plus4d_d = pc_plus4d_q;
    validd_d    = validd_q;

    if (redir)   pcf_d = redirect_pc;
    else if (hs) pcf_d = pc_inc(pcf_q);

    // On redirect every request left unanswered after this edge is stale.
    if (redir)                            discard_d = tag_cnt + CW'(hs) - CW'(data_ok);
    else if (data_ok && discard_q != '0)  discard_d = discard_q - CW'(1);

    if (!stallD) begin
      validd_d = 1'b0;
      instrd_d = NOP_WORD;
      if (!flushD && !redir) begin
        if (!buf_empty) begin
          validd_d    = 1'b1;
          instrd_d    = buf_head.instr;
          pcd_d       = buf_head.pc;
          pc_plus4d_d = pc_inc(buf_head.pc);
        end else if (bypass) begin
          validd_d    = 1'b1;
          instrd_d    = ibus.inst_rdata;
          pcd_d       = tag_head;
          pc_plus4d_d = pc_inc(tag_head);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcf_q       <= RESET_PC;
      discard_q   <= '0;
      instrd_q    <= NOP_WORD;
      pcd_q       <= 32'h0;
      pc_plus4d_q <= pc_inc(32'h0);
      validd_q    <= 1'b0;
    end else begin
      pcf_q       <= pcf_d;
      discard_q   <= discard_d;
      instrd_q    <= instrd_d;
      pcd_q       <= pcd_d;
      pc_plus4d_q <= pc_plus4d_d;
      validd_q    <= validd_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (1'b0),
    .push  (hs),
    .din   (pcf_q),
    .pop   (data_ok),
    .dout  (tag_head),
    .empty (tag_empty),
    .count (tag_cnt)
  );

  fetch_fifo #(.WIDTH($bits(fetch_resp_t)), .DEPTH(MAX_OUTST)) u_resp_buf (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (redir),
    .push  (buf_push),
    .din   (buf_in),
    .pop   (buf_pop),
    .dout  (buf_head),
    .empty (buf_empty),
    .count (buf_cnt)
  );

  assert property (@(posedge clk) disable iff (!resetn) !(data_ok && tag_empty));

  assign pcF       = pcf_q;
  assign instrD    = instrd_q;
  assign pcD       = pcd_q;
  assign pc_plus4D = pc_plus4d_q;
  assign validD    = validd_q;

endmodule
